// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Packs symbolic MIPS instruction descriptors into 32-bit words and writes
//   them to consecutive instruction-memory addresses.
//
//   Parameters
//     DEPTH      maximum words written per load session
//     BASE_ADDR  byte address of the first word written
//   Ports
//     i_clk, i_rst          clock (rising edge), async active-high reset
//     i_start               begin a session (honoured in IDLE/DONE only)
//     i_valid / o_ready     descriptor handshake
//     i_last                final descriptor of the session
//     i_kind, i_rs, i_rt, i_rd, i_funct, i_imm, i_target  descriptor fields
//     o_wr_en/addr/data     instruction-memory write port (1-cycle latency)
//     o_count               words written this session
//     o_done                one-cycle pulse after the i_last beat
//     o_err                 sticky illegal-descriptor flag
//
//   Optional feature macro: INSTR_ENC_FUNCT_CHECK_EN
//     When defined, RTYPE beats with an unsupported funct are illegal.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_last,
    input  logic [3:0]                   i_kind,
    input  logic [4:0]                   i_rs,
    input  logic [4:0]                   i_rt,
    input  logic [4:0]                   i_rd,
    input  logic [5:0]                   i_funct,
    input  logic [15:0]                  i_imm,
    input  logic [25:0]                  i_target,
    output logic                         o_wr_en,
    output logic [31:0]                  o_wr_addr,
    output logic [31:0]                  o_wr_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state, w_next;
    logic           r_wr_en, r_done, r_err;
    logic [31:0]    r_wr_addr, r_wr_data;
    // r_count is both the write index and the written-word count. It steps at
    // the same edge that raises o_wr_en, so no write is ever "pending" beyond
    // what the count already includes and ready can gate on it directly.
    logic [CW-1:0]  r_count;

    logic           w_accept, w_start, w_legal;
    logic [31:0]    w_word;

    assign o_ready  = (r_state == S_LOAD) && (r_count < DEPTH_C);
    assign w_accept = i_valid & o_ready;
    assign w_start  = i_start & (r_state != S_LOAD);

    // Descriptor encoder
    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (i_kind)
            4'd0: begin
                w_word = {6'b000000, i_rs, i_rt, i_rd, 5'b00000, i_funct};
`ifdef INSTR_ENC_FUNCT_CHECK_EN
                case (i_funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011: w_legal = 1'b1;
                    default:              w_legal = 1'b0;
                endcase
`endif
            end
            4'd1:    w_word = {6'b001000, i_rs, i_rt, i_imm};
            4'd2:    w_word = {6'b001001, i_rs, i_rt, i_imm};
            4'd3:    w_word = {6'b001010, i_rs, i_rt, i_imm};
            4'd4:    w_word = {6'b001100, i_rs, i_rt, i_imm};
            4'd5:    w_word = {6'b001101, i_rs, i_rt, i_imm};
            4'd6:    w_word = {6'b001110, i_rs, i_rt, i_imm};
            4'd7:    w_word = {6'b000010, i_target};
            4'd8:    w_word = {6'b000100, i_rs, i_rt, i_imm};
            4'd9:    w_word = {6'b000101, i_rs, i_rt, i_imm};
            4'd10:   w_word = {6'b100011, i_rs, i_rt, i_imm};
            4'd11:   w_word = {6'b101011, i_rs, i_rt, i_imm};
            default: w_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a full session without i_last simply parks in LOAD.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start)            w_next = S_LOAD;
            S_LOAD:         if (w_accept && i_last) w_next = S_DONE;
            default:                                w_next = S_IDLE;
        endcase
    end

    // Write port, count and error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= BASE_ADDR;
            r_wr_data <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_accept & w_legal;
            r_done  <= w_accept & i_last;
            if (w_start) begin
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_count   <= r_count + 1'b1;
                    r_wr_addr <= BASE_ADDR + (32'(r_count) << 2);
                    r_wr_data <= w_word;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_count   = r_count;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_valid, a_last;
    logic        b_start, b_valid, b_last;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    logic        a_ready, a_wr_en, a_done, a_err;
    logic [31:0] a_wr_addr, a_wr_data;
    logic [8:0]  a_count;
    logic        b_ready, b_wr_en, b_done, b_err;
    logic [31:0] b_wr_addr, b_wr_data;
    logic [2:0]  b_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_valid(a_valid),
        .o_ready(a_ready), .i_last(a_last), .i_kind(kind), .i_rs(rs),
        .i_rt(rt), .i_rd(rd), .i_funct(funct), .i_imm(imm), .i_target(target),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
        .o_count(a_count), .o_done(a_done), .o_err(a_err)
    );

    instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_valid(b_valid),
        .o_ready(b_ready), .i_last(b_last), .i_kind(kind), .i_rs(rs),
        .i_rt(rt), .i_rd(rd), .i_funct(funct), .i_imm(imm), .i_target(target),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_count(b_count), .o_done(b_done), .o_err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: opcode table indexed by kind, format chosen by class.
    logic [5:0] OPC [0:11];

    function automatic logic [32:0] ref_enc(input logic [3:0] k, input logic [4:0] s,
                                            input logic [4:0] t, input logic [4:0] d,
                                            input logic [5:0] f, input logic [15:0] im,
                                            input logic [25:0] tg);
        logic ok;
        logic [31:0] w;
        ok = (k < 4'd12);
        w  = '0;
        if (ok) begin
            if (k == 4'd0) begin
                w = {6'b0, s, t, d, 5'b0, f};
`ifdef INSTR_ENC_FUNCT_CHECK_EN
                ok = f inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
`endif
            end else if (k == 4'd7) begin
                w = {OPC[7], tg};
            end else begin
                w = {OPC[k], s, t, im};
            end
        end
        return {ok, w};
    endfunction

    typedef struct {
        logic [3:0]  k;
        logic [4:0]  s, t, d;
        logic [5:0]  f;
        logic [15:0] im;
        logic [25:0] tg;
        logic        legal;
        logic [31:0] data;
    } vec_t;

    vec_t vt [0:9];

    task automatic drive(input vec_t v);
        kind = v.k; rs = v.s; rt = v.t; rd = v.d;
        funct = v.f; imm = v.im; target = v.tg;
    endtask

    initial begin
        int widx;
        int sent, mcount, acc_n, wr_n, done_n;
        logic merr, acc, expwr, seen_low;
        logic [32:0] r;

        OPC = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h02, 6'h04, 6'h05, 6'h23, 6'h2B};

        vt[0] = '{4'd0,  5'd1,  5'd2, 5'd3, 6'h20, 16'h0000, 26'h0,  1'b1, 32'h00221820};
        vt[1] = '{4'd7,  5'd0,  5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 1'b1, 32'h08000010};
        vt[2] = '{4'd11, 5'd29, 5'd2, 5'd0, 6'h00, 16'h0004, 26'h0,  1'b1, 32'hAFA20004};
        vt[3] = '{4'd8,  5'd1,  5'd2, 5'd0, 6'h00, 16'hFFFF, 26'h0,  1'b1, 32'h1022FFFF};
        vt[4] = '{4'd13, 5'd1,  5'd2, 5'd3, 6'h20, 16'h1234, 26'h0,  1'b0, 32'h0};
        vt[5] = '{4'd2,  5'd3,  5'd4, 5'd0, 6'h00, 16'h8000, 26'h0,  1'b1, 32'h24648000};
`ifdef INSTR_ENC_FUNCT_CHECK_EN
        vt[6] = '{4'd0,  5'd1,  5'd2, 5'd3, 6'h01, 16'h0000, 26'h0,  1'b0, 32'h0};
`else
        vt[6] = '{4'd0,  5'd1,  5'd2, 5'd3, 6'h01, 16'h0000, 26'h0,  1'b1, 32'h00221801};
`endif
        vt[7] = '{4'd10, 5'd29, 5'd8, 5'd0, 6'h00, 16'h0010, 26'h0,  1'b1, 32'h8FA80010};
        vt[8] = '{4'd9,  5'd4,  5'd0, 5'd0, 6'h00, 16'hFFFE, 26'h0,  1'b1, 32'h1480FFFE};
        vt[9] = '{4'd5,  5'd0,  5'd9, 5'd0, 6'h00, 16'hABCD, 26'h0,  1'b1, 32'h3409ABCD};

        rst = 1'b1;
        a_start = 0; a_valid = 0; a_last = 0;
        b_start = 0; b_valid = 0; b_last = 0;
        drive(vt[0]);
        step(); step();
        // Reset values
        chk("rst_ready",  32'(a_ready),  0);
        chk("rst_wr_en",  32'(a_wr_en),  0);
        chk("rst_addr",   a_wr_addr,     0);
        chk("rst_data",   a_wr_data,     0);
        chk("rst_count",  32'(a_count),  0);
        chk("rst_done",   32'(a_done),   0);
        chk("rst_err",    32'(a_err),    0);
        rst = 1'b0;
        step();

        // Single ADDI with i_last
        a_start = 1; step(); a_start = 0;
        chk("start_ready", 32'(a_ready), 1);
        kind = 4'd1; rs = 5'd0; rt = 5'd8; imm = 16'h0005;
        a_valid = 1; a_last = 1;
        step();
        a_valid = 0; a_last = 0;
        chk("addi_wr_en", 32'(a_wr_en), 1);
        chk("addi_addr",  a_wr_addr,    32'h0);
        chk("addi_data",  a_wr_data,    32'h20080005);
        chk("addi_done",  32'(a_done),  1);
        chk("addi_count", 32'(a_count), 1);
        chk("addi_ready_done", 32'(a_ready), 0);
        step();
        chk("addi_wr_en_drop", 32'(a_wr_en), 0);
        chk("addi_done_drop",  32'(a_done),  0);

        // Table session: back-to-back beats, including illegal kind mid-stream
        a_start = 1; step(); a_start = 0;
        widx = 0;
        for (int i = 0; i < 10; i++) begin
            drive(vt[i]);
            a_valid = 1; a_last = (i == 9);
            step();
            chk($sformatf("tbl%0d_wr_en", i), 32'(a_wr_en), 32'(vt[i].legal));
            if (vt[i].legal) begin
                chk($sformatf("tbl%0d_addr", i), a_wr_addr, 32'(widx * 4));
                chk($sformatf("tbl%0d_data", i), a_wr_data, vt[i].data);
                widx++;
            end
            chk($sformatf("tbl%0d_count", i), 32'(a_count), 32'(widx));
            if (i >= 4) chk($sformatf("tbl%0d_err", i), 32'(a_err), 1);
            else        chk($sformatf("tbl%0d_err", i), 32'(a_err), 0);
            chk($sformatf("tbl%0d_done", i), 32'(a_done), 32'(i == 9));
        end
        a_valid = 0; a_last = 0;
        step();
        chk("tbl_err_sticky", 32'(a_err), 1);
        a_start = 1; step(); a_start = 0;
        chk("start_clr_err",   32'(a_err),   0);
        chk("start_clr_count", 32'(a_count), 0);

        // Randomized session against the reference model
        sent = 0; mcount = 0; merr = 0;
        for (int n = 0; n < 1000 && sent < 150; n++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            kind  = ($urandom_range(0, 7) == 0) ? 4'(12 + $urandom_range(0, 3))
                                                : 4'($urandom_range(0, 11));
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            funct = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                                : 6'(32 + $urandom_range(0, 7));
            imm = 16'($urandom); target = 26'($urandom);
            a_last = (sent == 149);
            chk("rnd_ready", 32'(a_ready), 1);
            acc = a_valid && a_ready;
            r = ref_enc(kind, rs, rt, rd, funct, imm, target);
            step();
            expwr = acc && r[32];
            chk("rnd_wr_en", 32'(a_wr_en), 32'(expwr));
            if (expwr) begin
                chk("rnd_addr", a_wr_addr, 32'(mcount * 4));
                chk("rnd_data", a_wr_data, r[31:0]);
                mcount++;
            end
            if (acc) begin
                if (!r[32]) merr = 1;
                sent++;
            end
            chk("rnd_count", 32'(a_count), 32'(mcount));
            chk("rnd_err",   32'(a_err),   32'(merr));
            chk("rnd_done",  32'(a_done),  32'(acc && sent == 150));
        end
        a_valid = 0; a_last = 0;
        chk("rnd_all_sent", 32'(sent), 150);
        chk("rnd_end_ready", 32'(a_ready), 0);

        // Reset right after an accept: the write is dropped
        a_start = 1; step(); a_start = 0;
        drive(vt[0]); a_valid = 1;
        step();
        a_valid = 0;
        rst = 1'b1;
        #1;
        chk("rstl_wr_en", 32'(a_wr_en), 0);
        chk("rstl_ready", 32'(a_ready), 0);
        chk("rstl_count", 32'(a_count), 0);
        chk("rstl_addr",  a_wr_addr,    0);
        chk("rstl_data",  a_wr_data,    0);
        chk("rstl_done",  32'(a_done),  0);
        step();
        rst = 1'b0;
        step();
        chk("rstl_idle_ready", 32'(a_ready), 0);
        chk("rstl_wr_en_hold", 32'(a_wr_en), 0);

        // DEPTH=4: five beats without i_last, fifth stalls
        b_start = 1; step(); b_start = 0;
        drive(vt[5]); b_valid = 1; b_last = 0;
        acc_n = 0; wr_n = 0; done_n = 0; seen_low = 0;
        for (int n = 0; n < 12; n++) begin
            acc = b_ready;
            step();
            if (acc) acc_n++;
            if (b_wr_en) wr_n++;
            if (b_done) done_n++;
            if (acc && acc_n == 4) seen_low = !b_ready;
        end
        b_valid = 0;
        chk("d4_accepts", 32'(acc_n), 4);
        chk("d4_writes",  32'(wr_n),  4);
        chk("d4_no_done", 32'(done_n), 0);
        chk("d4_ready_low_after_4th", 32'(seen_low), 1);
        chk("d4_count",   32'(b_count), 4);
        chk("d4_last_addr", b_wr_addr, 32'hC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
